// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul tile scheduler and its write-back engine.
// Widths are fixed here so every file agrees on address, data and dimension sizes.
package matmul_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int DIM_WIDTH      = 16;
  localparam int TILE           = 8;
  localparam int BW             = 4;
  localparam int BEATS_PER_TILE = TILE * TILE / BW;
  localparam int BEAT_WIDTH     = $clog2(BEATS_PER_TILE);
  localparam int COL_WIDTH      = $clog2(TILE);
  localparam int TCNT_WIDTH     = DIM_WIDTH - 3;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DIM_WIDTH-1:0]  dim_t;
  typedef logic [TCNT_WIDTH-1:0] tcnt_t;
  typedef logic [TILE-1:0][TILE-1:0][DATA_WIDTH-1:0] tile_t;
  typedef logic [BW-1:0][DATA_WIDTH-1:0] beat_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_RUN,
    S_HOLD,
    S_ADVANCE,
    S_DRAIN
  } fsm_state_t;

  // base + idx*TILE*stride, all at ADDR_WIDTH so the result wraps modulo 2^ADDR_WIDTH.
  function automatic addr_t tile_offset(input addr_t base, input tcnt_t idx, input dim_t stride);
    return base + addr_t'(idx) * addr_t'(TILE) * addr_t'(stride);
  endfunction

endpackage

// File: rtl/tile_writeback.sv
// Holds one captured 8x8 output tile and streams it to memory as 16 beats of BW words.
// Tile indices are latched at capture so the FSM can move on to the next tile immediately.
module tile_writeback
  import matmul_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  capture,
  input  tile_t cap_tile,
  input  tcnt_t cap_ti,
  input  tcnt_t cap_tj,
  input  addr_t base_c,
  input  dim_t  dim_n,
  input  logic  write_ready,
  output logic  free,
  output logic  write,
  output addr_t write_addr,
  output beat_t writedata
);

  tile_t                 buf_q;
  logic                  full_q;
  logic [BEAT_WIDTH-1:0] beat_q;
  tcnt_t                 ti_q;
  tcnt_t                 tj_q;

  logic                  accept;
  logic                  last_accept;
  logic [BEAT_WIDTH-2:0] row;
  logic                  half;
  addr_t                 row_addr;
  logic [COL_WIDTH-1:0]  col;

  // Handshake: a beat transfers on a cycle where write & write_ready are both high;
  // while write is high and write_ready is low, write_addr and writedata hold steady.
  assign accept      = full_q && write_ready;
  assign last_accept = accept && (beat_q == BEAT_WIDTH'(BEATS_PER_TILE - 1));
  // The buffer may be reloaded in the same cycle its final beat is taken.
  assign free        = !full_q || last_accept;
  assign write       = full_q;
  assign row         = beat_q[BEAT_WIDTH-1:1];
  assign half        = beat_q[0];
  assign row_addr    = addr_t'(ti_q) * addr_t'(TILE) + addr_t'(row);

  always_comb begin
    write_addr = '0;
    if (full_q) begin
      write_addr = base_c + row_addr * addr_t'(dim_n)
                 + addr_t'(tj_q) * addr_t'(TILE) + addr_t'(half) * addr_t'(BW);
    end
  end

  always_comb begin
    writedata = '0;
    col       = '0;
    if (full_q) begin
      for (int c = 0; c < BW; c++) begin
        col          = COL_WIDTH'(int'(half) * BW + c);
        writedata[c] = buf_q[row][col];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q <= 1'b0;
      beat_q <= '0;
      ti_q   <= '0;
      tj_q   <= '0;
    end else if (capture) begin
      full_q <= 1'b1;
      beat_q <= '0;
      ti_q   <= cap_ti;
      tj_q   <= cap_tj;
    end else if (accept) begin
      beat_q <= beat_q + BEAT_WIDTH'(1);
      if (last_accept) begin
        full_q <= 1'b0;
      end
    end
  end

  // Tile data needs no reset: it is only observed while full_q is set.
  always_ff @(posedge clock) begin
    if (capture) begin
      buf_q <= cap_tile;
    end
  end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Walks the 8x8 output tiles of C = A x B in row-major order, launching the systolic
// driver once per tile and handing each finished tile to the write-back engine.
module matmul_tile_scheduler
  import matmul_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  addr_t      base_A,
  input  addr_t      base_B,
  input  addr_t      base_C,
  input  dim_t       dim_M,
  input  dim_t       dim_K,
  input  dim_t       dim_N,
  output logic       drv_start,
  output addr_t      drv_base_A,
  output addr_t      drv_base_B,
  output dim_t       drv_dim_col_A,
  output dim_t       drv_dim_col_B,
  input  logic       drv_done,
  input  tile_t      drv_Out,
  output logic       write,
  input  logic       write_ready,
  output addr_t      write_addr,
  output beat_t      writedata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output fsm_state_t dbg_state
);

  fsm_state_t state;
  addr_t      base_a_r;
  addr_t      base_b_r;
  addr_t      base_c_r;
  dim_t       dim_m_r;
  dim_t       dim_k_r;
  dim_t       dim_n_r;
  tcnt_t      i_q;
  tcnt_t      j_q;

  tcnt_t      tiles_m;
  tcnt_t      tiles_n;
  tcnt_t      nxt_i;
  tcnt_t      nxt_j;
  logic       last_col;
  logic       last_tile;
  logic       dims_bad;
  logic       wb_free;
  logic       capture;

  assign tiles_m   = dim_m_r[DIM_WIDTH-1:3];
  assign tiles_n   = dim_n_r[DIM_WIDTH-1:3];
  assign last_col  = (j_q == tiles_n - tcnt_t'(1));
  assign last_tile = last_col && (i_q == tiles_m - tcnt_t'(1));
  assign nxt_j     = last_col ? '0 : j_q + tcnt_t'(1);
  assign nxt_i     = last_col ? i_q + tcnt_t'(1) : i_q;
  assign dims_bad  = (dim_m_r == '0) || (dim_k_r == '0) || (dim_n_r == '0) ||
                     (dim_m_r[2:0] != 3'd0) || (dim_n_r[2:0] != 3'd0);
  // The driver holds drv_Out until the next drv_start, so a tile can wait in HOLD.
  assign capture   = wb_free && ((state == S_RUN && drv_done) || state == S_HOLD);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      base_a_r      <= '0;
      base_b_r      <= '0;
      base_c_r      <= '0;
      dim_m_r       <= '0;
      dim_k_r       <= '0;
      dim_n_r       <= '0;
      i_q           <= '0;
      j_q           <= '0;
      drv_start     <= 1'b0;
      drv_base_A    <= '0;
      drv_base_B    <= '0;
      drv_dim_col_A <= '0;
      drv_dim_col_B <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      drv_start <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_a_r <= base_A;
            base_b_r <= base_B;
            base_c_r <= base_C;
            dim_m_r  <= dim_M;
            dim_k_r  <= dim_K;
            dim_n_r  <= dim_N;
            i_q      <= '0;
            j_q      <= '0;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (dims_bad) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            drv_start     <= 1'b1;
            drv_base_A    <= base_a_r;
            drv_base_B    <= base_b_r;
            drv_dim_col_A <= dim_k_r;
            drv_dim_col_B <= dim_n_r;
            state         <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_RUN;
        S_RUN: begin
          if (drv_done) begin
            state <= capture ? S_ADVANCE : S_HOLD;
          end
        end
        S_HOLD: begin
          if (capture) begin
            state <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (last_tile) begin
            state <= S_DRAIN;
          end else begin
            i_q        <= nxt_i;
            j_q        <= nxt_j;
            drv_start  <= 1'b1;
            drv_base_A <= tile_offset(base_a_r, nxt_i, dim_k_r);
            drv_base_B <= tile_offset(base_b_r, nxt_j, dim_t'(1));
            state      <= S_LAUNCH;
          end
        end
        S_DRAIN: begin
          if (wb_free) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  tile_writeback u_writeback (
    .clock       (clock),
    .reset       (reset),
    .capture     (capture),
    .cap_tile    (drv_Out),
    .cap_ti      (i_q),
    .cap_tj      (j_q),
    .base_c      (base_c_r),
    .dim_n       (dim_n_r),
    .write_ready (write_ready),
    .free        (wb_free),
    .write       (write),
    .write_addr  (write_addr),
    .writedata   (writedata)
  );

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: a stub systolic driver with random tile contents and
// a matrix-coordinate reference model predicting every launch and every write beat.
module tb_matmul_tile_scheduler;
  import matmul_pkg::*;

  localparam int STUB_LAT = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  addr_t      base_A, base_B, base_C;
  dim_t       dim_M, dim_K, dim_N;
  logic       drv_start;
  addr_t      drv_base_A, drv_base_B;
  dim_t       drv_dim_col_A, drv_dim_col_B;
  logic       drv_done;
  tile_t      drv_Out;
  logic       write;
  logic       write_ready;
  addr_t      write_addr;
  beat_t      writedata;
  logic       busy, done, err;
  fsm_state_t dbg_state;

  matmul_tile_scheduler dut (
    .clock         (clk),
    .reset         (reset),
    .start         (start),
    .base_A        (base_A),
    .base_B        (base_B),
    .base_C        (base_C),
    .dim_M         (dim_M),
    .dim_K         (dim_K),
    .dim_N         (dim_N),
    .drv_start     (drv_start),
    .drv_base_A    (drv_base_A),
    .drv_base_B    (drv_base_B),
    .drv_dim_col_A (drv_dim_col_A),
    .drv_dim_col_B (drv_dim_col_B),
    .drv_done      (drv_done),
    .drv_Out       (drv_Out),
    .write         (write),
    .write_ready   (write_ready),
    .write_addr    (write_addr),
    .writedata     (writedata),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  logic [31:0]              exp_la_q[$];
  logic [31:0]              exp_lb_q[$];
  logic [31:0]              exp_addr_q[$];
  logic [BW*DATA_WIDTH-1:0] exp_data_q[$];
  logic [31:0]              got_addr_q[$];

  int          launches_seen    = 0;
  int          beats_seen       = 0;
  int          last_beat_cyc    = 0;
  int          first_launch_cyc = -1;
  int          hold_cycles      = 0;
  int          job_k            = 0;
  int          cur_k, cur_n, cur_tn;
  logic [31:0] cur_c;
  int          ready_mode       = 0;
  int          stub_cnt         = 0;
  tile_t       pend;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- stub driver + write_ready driver ----------------
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      drv_done = 1'b0;
      stub_cnt = 0;
    end else if (drv_start) begin
      launches_seen++;
      chk("launch_expected", exp_la_q.size() > 0, 1'b1);
      if (exp_la_q.size() > 0) begin
        int ti, tj;
        chk("drv_base_A", drv_base_A, exp_la_q.pop_front());
        chk("drv_base_B", drv_base_B, exp_lb_q.pop_front());
        chk("drv_dim_col_A", drv_dim_col_A, cur_k);
        chk("drv_dim_col_B", drv_dim_col_B, cur_n);
        if (job_k == 0) first_launch_cyc = cyc;
        for (int r = 0; r < TILE; r++)
          for (int c = 0; c < TILE; c++)
            pend[r][c] = $urandom();
        ti = job_k / cur_tn;
        tj = job_k % cur_tn;
        // C[row][col] lives at base_C + row*N + col; each beat carries 4 consecutive columns.
        for (int r = 0; r < TILE; r++) begin
          for (int h = 0; h < 2; h++) begin
            logic [BW*DATA_WIDTH-1:0] d;
            logic [31:0] row_w, col_w;
            row_w = 32'(ti * 8 + r);
            col_w = 32'(tj * 8 + h * 4);
            for (int c = 0; c < BW; c++) d[c*DATA_WIDTH +: DATA_WIDTH] = pend[r][h*4+c];
            exp_addr_q.push_back(cur_c + row_w * 32'(cur_n) + col_w);
            exp_data_q.push_back(d);
          end
        end
        job_k++;
      end
      drv_done = 1'b0;
      stub_cnt = STUB_LAT;
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        drv_done = 1'b1;
        drv_Out  = pend;
      end
    end
    case (ready_mode)
      1:       write_ready = ~write_ready;
      2:       write_ready = 1'($urandom_range(0, 1));
      default: write_ready = 1'b1;
    endcase
  end

  // ---------------- write monitor / scoreboard ----------------
  bit          stalled = 0;
  logic [31:0] hold_addr;
  beat_t       hold_data;

  always @(negedge clk) begin
    if (reset) begin
      stalled = 0;
    end else begin
      if (dbg_state == S_HOLD) hold_cycles++;
      if (write) begin
        if (stalled) begin
          chk("stall_addr_stable", write_addr, hold_addr);
          chk("stall_data_stable", writedata, hold_data);
        end
        if (write_ready) begin
          chk("beat_expected", exp_addr_q.size() > 0, 1'b1);
          if (exp_addr_q.size() > 0) begin
            chk("write_addr", write_addr, exp_addr_q.pop_front());
            chk("writedata", writedata, exp_data_q.pop_front());
          end
          got_addr_q.push_back(write_addr);
          beats_seen++;
          last_beat_cyc = cyc;
          stalled = 0;
        end else begin
          stalled   = 1;
          hold_addr = write_addr;
          hold_data = writedata;
        end
      end else begin
        stalled = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic setup_job(input int m, input int k, input int n,
                           input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc,
                           output int ntiles);
    bit bad;
    bad    = (m == 0) || (k == 0) || (n == 0) || (m % 8 != 0) || (n % 8 != 0);
    ntiles = bad ? 0 : (m / 8) * (n / 8);
    cur_k  = k;
    cur_n  = n;
    cur_c  = bc;
    cur_tn = (n / 8 > 0) ? n / 8 : 1;
    job_k  = 0;
    first_launch_cyc = -1;
    if (!bad)
      for (int ti = 0; ti < m / 8; ti++)
        for (int tj = 0; tj < n / 8; tj++) begin
          exp_la_q.push_back(ba + 32'(ti * 8) * 32'(k));
          exp_lb_q.push_back(bb + 32'(tj * 8));
        end
    base_A = ba;
    base_B = bb;
    base_C = bc;
    dim_M  = dim_t'(m);
    dim_K  = dim_t'(k);
    dim_N  = dim_t'(n);
  endtask

  task automatic run_job(input string tag, input int m, input int k, input int n,
                         input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc,
                         input bit repulse, output int dur, output int g0);
    int ntiles, l0, b0, start_c, done_c, err_c;
    setup_job(m, k, n, ba, bb, bc, ntiles);
    l0 = launches_seen;
    b0 = beats_seen;
    g0 = got_addr_q.size();
    done_c = -1;
    err_c  = -1;
    @(negedge clk);
    start   = 1'b1;
    start_c = cyc;
    for (int w = 0; w < 3000 && done_c < 0 && err_c < 0; w++) begin
      @(negedge clk);
      start = repulse && (w == 12);
      dim_M = (repulse && w == 12) ? dim_t'(8) : dim_t'(m);
      if (done) done_c = cyc;
      if (err)  err_c  = cyc;
    end
    start = 1'b0;
    dim_M = dim_t'(m);
    if (ntiles == 0) begin
      chk({tag, "_err_seen"}, err_c >= 0, 1'b1);
      chk({tag, "_err_latency"}, 32'(err_c - start_c), 32'd2);
      chk({tag, "_no_done"}, done_c < 0, 1'b1);
    end else begin
      chk({tag, "_done_seen"}, done_c >= 0, 1'b1);
      chk({tag, "_no_err"}, err_c < 0, 1'b1);
      chk({tag, "_done_after_last_beat"}, 32'(done_c - last_beat_cyc), 32'd1);
      chk({tag, "_first_launch_latency"}, 32'(first_launch_cyc - start_c), 32'd2);
    end
    chk({tag, "_launch_count"}, launches_seen - l0, ntiles);
    chk({tag, "_beat_count"}, beats_seen - b0, ntiles * BEATS_PER_TILE);
    chk({tag, "_beats_left"}, exp_addr_q.size(), 0);
    chk({tag, "_launches_left"}, exp_la_q.size(), 0);
    @(negedge clk);
    chk({tag, "_pulses_cleared"}, {done, err}, 2'b00);
    chk({tag, "_busy_dropped"}, busy, 1'b0);
    dur = done_c - start_c;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dur, g0, dur2, nt, b0, w;
    reset = 1'b1;
    start = 1'b0;
    base_A = '0; base_B = '0; base_C = '0;
    dim_M = '0; dim_K = '0; dim_N = '0;
    drv_done = 1'b0;
    drv_Out = '0;
    write_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_drv_start", drv_start, 1'b0);
    chk("rst_write", write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done_err", {done, err}, 2'b00);
    chk("rst_write_addr", write_addr, 32'd0);
    chk("rst_writedata", writedata, '0);
    chk("rst_drv_bases", {drv_base_A, drv_base_B}, 64'd0);
    chk("rst_drv_dims", {drv_dim_col_A, drv_dim_col_B}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single tile, known addresses
    ready_mode = 0;
    run_job("t1", 8, 8, 8, 32'd0, 32'd70, 32'd200, 1'b0, dur, g0);
    if (got_addr_q.size() >= g0 + 16) begin
      chk("t1_first_addr", got_addr_q[g0], 32'd200);
      chk("t1_last_addr", got_addr_q[g0+15], 32'd260);
    end

    // 2x2 tiles
    run_job("t2", 16, 8, 16, 32'd0, 32'd70, 32'd200, 1'b0, dur2, g0);
    if (got_addr_q.size() >= g0 + 64) chk("t2_tile11_beat0", got_addr_q[g0+48], 32'd336);

    // write_ready toggling forces HOLD and stalls
    ready_mode  = 1;
    hold_cycles = 0;
    run_job("t3", 16, 8, 16, $urandom(), $urandom(), $urandom(), 1'b0, dur, g0);
    chk("t3_hold_entered", hold_cycles > 0, 1'b1);

    // random shapes with random back-pressure
    ready_mode = 2;
    for (int t = 0; t < 3; t++)
      run_job("trand", 8 * $urandom_range(1, 3), $urandom_range(1, 40), 8 * $urandom_range(1, 3),
              $urandom(), $urandom(), $urandom(), 1'b0, dur, g0);

    // bad dimensions
    ready_mode = 0;
    run_job("t4_m12", 12, 8, 8, 32'd0, 32'd70, 32'd200, 1'b0, dur, g0);
    run_job("t4_k0", 8, 0, 8, 32'd0, 32'd70, 32'd200, 1'b0, dur, g0);

    // reset in the middle of write-back
    setup_job(8, 8, 8, 32'd0, 32'd70, 32'd200, nt);
    b0 = beats_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (beats_seen - b0 < 7 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("t5_reached_beat7", beats_seen - b0, 7);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_write_low", write, 1'b0);
    chk("t5_busy_low", busy, 1'b0);
    chk("t5_done_low", done, 1'b0);
    chk("t5_drv_start_low", drv_start, 1'b0);
    @(posedge clk);
    #1;
    chk("t5_beats_frozen", beats_seen - b0, 7);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_la_q.delete();
    exp_lb_q.delete();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_job("t5_rerun", 8, 8, 8, 32'd0, 32'd70, 32'd200, 1'b0, dur, g0);
    if (got_addr_q.size() >= g0 + 16) chk("t5_rerun_first_addr", got_addr_q[g0], 32'd200);

    // start re-pulsed while busy
    run_job("t6", 16, 8, 16, 32'd0, 32'd70, 32'd200, 1'b1, dur, g0);
    chk("t6_same_duration", 32'(dur), 32'(dur2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycles=%0d checks=%0d failures=%0d", cyc, checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
